// File: rtl/pwm_soft_start_sequencer_if.sv
// Wishbone slave bus bundle for the PWM soft-start sequencer.
// The master modport drives requests; the slave modport answers them.
interface pwm_soft_start_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i,
        output wbs_cyc_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i,
        input  wbs_cyc_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/pwm_soft_start_sequencer.sv
// PWM soft-start sequencer.
// Ramps four PWM duty values from 0 up to programmed targets, ramps them
// back down on STOP and forces them to 0 on a driver fault. Configured over
// a Wishbone slave port (CTRL / TARGET / STEP_DIV / STATUS).
// Build option: define PWM_SEQ_STAGGER_EN to ramp channels one after another
// during RAMP; otherwise all channels ramp in parallel.
module pwm_soft_start_sequencer #(
    parameter int DUTY_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    pwm_soft_start_sequencer_if.slave wbs,
    input  logic                     fault_i,
    output logic [4*DUTY_W-1:0]      duty_o,
    output logic [1:0]               irq_o
);

    // STOPPING is an internal state; it reports as RAMP on STATUS.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FAULT = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] ADR_CTRL   = 2'd0;
    localparam logic [1:0] ADR_TARGET = 2'd1;
    localparam logic [1:0] ADR_DIV    = 2'd2;
    localparam logic [1:0] ADR_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_adr;
    logic              ack_reg;
    logic [31:0]       dat_reg;
    logic              start_reg;
    logic              stop_reg;
    logic              clr_reg;
    logic [DUTY_W-1:0] target_reg [4];
    logic [DIV_W-1:0]  step_div_reg;
    logic [31:0]       target_rd;
    logic [31:0]       rd_data;
    logic [1:0]        state_code;
    logic [1:0]        ch_code;
    logic              unused_bus;

    // ------------------------------------------------------------------
    // Sequencer side
    // ------------------------------------------------------------------
    logic              fault_meta_reg;
    logic              fault_sync_reg;
    logic              fault_prev_reg;
    logic              fault_rise;
    logic              fault_latch_reg;
    logic              fault_latch_next;
    state_t            state_reg;
    state_t            state_next;
    logic [DUTY_W-1:0] duty_reg    [4];
    logic [DUTY_W-1:0] duty_next   [4];
    logic [DUTY_W-1:0] duty_toward [4];
    logic [DUTY_W-1:0] duty_dec    [4];
    logic [3:0]        at_target;
    logic [3:0]        is_zero;
    logic [1:0]        irq_reg;
    logic [1:0]        irq_next;
    logic [DIV_W-1:0]  presc_reg;
    logic              tick;
`ifdef PWM_SEQ_STAGGER_EN
    logic [1:0]        ch_reg;
    logic [1:0]        ch_next;
`endif

    assign bus_req = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_reg;
    assign bus_wr  = bus_req & wbs.wbs_we_i;
    assign bus_adr = wbs.wbs_adr_i[3:2];

    // Only address bits [3:2] select a register.
    assign unused_bus = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0]};

    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = dat_reg;

    // Per-channel helpers: step toward target, step toward zero, packing.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            assign at_target[gi]   = (duty_reg[gi] == target_reg[gi]);
            assign is_zero[gi]     = (duty_reg[gi] == '0);
            assign duty_toward[gi] = (duty_reg[gi] < target_reg[gi]) ? duty_reg[gi] + DUTY_W'(1) :
                                     (duty_reg[gi] > target_reg[gi]) ? duty_reg[gi] - DUTY_W'(1) :
                                                                       duty_reg[gi];
            assign duty_dec[gi]    = is_zero[gi] ? '0 : duty_reg[gi] - DUTY_W'(1);
            assign duty_o[gi*DUTY_W +: DUTY_W] = duty_reg[gi];
            assign target_rd[gi*8 +: 8]        = 8'(target_reg[gi]);
        end
    endgenerate

`ifdef PWM_SEQ_STAGGER_EN
    assign ch_code = ch_reg;
`else
    assign ch_code = 2'd0;
`endif

    // Software-visible state code; stopping reports as RAMP.
    always_comb begin
        state_code = 2'd0;
        case (state_reg)
            ST_IDLE:  state_code = 2'd0;
            ST_RAMP:  state_code = 2'd1;
            ST_STOP:  state_code = 2'd1;
            ST_RUN:   state_code = 2'd2;
            ST_FAULT: state_code = 2'd3;
            default:  state_code = 2'd0;
        endcase
    end

    // Register read multiplexer; CTRL and unused bits read as 0.
    always_comb begin
        rd_data = '0;
        case (bus_adr)
            ADR_CTRL:   rd_data = '0;
            ADR_TARGET: rd_data = target_rd;
            ADR_DIV:    rd_data = 32'(step_div_reg);
            ADR_STATUS: rd_data = {26'd0, fault_sync_reg, fault_latch_reg, ch_code, state_code};
            default:    rd_data = '0;
        endcase
    end

    // Wishbone slave: single-cycle ack, register writes, CTRL command pulses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
            clr_reg      <= 1'b0;
            step_div_reg <= '0;
            for (int n = 0; n < 4; n++) begin
                target_reg[n] <= '0;
            end
        end else begin
            ack_reg   <= bus_req;
            dat_reg   <= (bus_req && !wbs.wbs_we_i) ? rd_data : '0;
            start_reg <= bus_wr && (bus_adr == ADR_CTRL) && wbs.wbs_dat_i[0];
            stop_reg  <= bus_wr && (bus_adr == ADR_CTRL) && wbs.wbs_dat_i[1];
            clr_reg   <= bus_wr && (bus_adr == ADR_CTRL) && wbs.wbs_dat_i[2];
            if (bus_wr && (bus_adr == ADR_TARGET)) begin
                for (int n = 0; n < 4; n++) begin
                    if (wbs.wbs_sel_i[n]) begin
                        target_reg[n] <= wbs.wbs_dat_i[n*8 +: DUTY_W];
                    end
                end
            end
            if (bus_wr && (bus_adr == ADR_DIV)) begin
                for (int b = 0; b < DIV_W; b++) begin
                    if (wbs.wbs_sel_i[b/8]) begin
                        step_div_reg[b] <= wbs.wbs_dat_i[b];
                    end
                end
            end
        end
    end

    // Two-flop synchronizer for the fault pin plus a delayed copy for edge detect.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            fault_meta_reg <= 1'b0;
            fault_sync_reg <= 1'b0;
            fault_prev_reg <= 1'b0;
        end else begin
            fault_meta_reg <= fault_i;
            fault_sync_reg <= fault_meta_reg;
            fault_prev_reg <= fault_sync_reg;
        end
    end

    assign fault_rise = fault_sync_reg & ~fault_prev_reg;

    // Ramp prescaler: tick at STEP_DIV, restart on every state change.
    // The >= keeps it wrapping promptly if STEP_DIV is lowered mid-count.
    assign tick = (presc_reg >= step_div_reg);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            presc_reg <= '0;
        end else if ((state_next != state_reg) || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + DIV_W'(1);
        end
    end

    // Sequencer state, duties, latched fault and interrupt pulses.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg       <= ST_IDLE;
            fault_latch_reg <= 1'b0;
            irq_reg         <= '0;
`ifdef PWM_SEQ_STAGGER_EN
            ch_reg          <= '0;
`endif
            for (int n = 0; n < 4; n++) begin
                duty_reg[n] <= '0;
            end
        end else begin
            state_reg       <= state_next;
            fault_latch_reg <= fault_latch_next;
            irq_reg         <= irq_next;
`ifdef PWM_SEQ_STAGGER_EN
            ch_reg          <= ch_next;
`endif
            for (int n = 0; n < 4; n++) begin
                duty_reg[n] <= duty_next[n];
            end
        end
    end

    // Next-state logic. Priority: fault edge, then STOP, then START.
    always_comb begin
        state_next       = state_reg;
        duty_next        = duty_reg;
        irq_next         = '0;
        fault_latch_next = fault_latch_reg;
`ifdef PWM_SEQ_STAGGER_EN
        ch_next          = ch_reg;
`endif

        // A clear only counts once the synced fault has dropped.
        if (clr_reg && !fault_sync_reg) begin
            fault_latch_next = 1'b0;
        end

        if (fault_rise) begin
            state_next       = ST_FAULT;
            irq_next[1]      = 1'b1;
            fault_latch_next = 1'b1;
`ifdef PWM_SEQ_STAGGER_EN
            ch_next          = '0;
`endif
            for (int n = 0; n < 4; n++) begin
                duty_next[n] = '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    for (int n = 0; n < 4; n++) begin
                        duty_next[n] = '0;
                    end
                    if (start_reg) begin
                        state_next = ST_RAMP;
`ifdef PWM_SEQ_STAGGER_EN
                        ch_next    = '0;
`endif
                    end
                end

                ST_RAMP: begin
                    if (stop_reg) begin
                        state_next = ST_STOP;
`ifdef PWM_SEQ_STAGGER_EN
                        ch_next    = '0;
`endif
                    end else if (tick) begin
`ifdef PWM_SEQ_STAGGER_EN
                        // One channel at a time; an equal compare at a tick moves on.
                        if (!at_target[ch_reg]) begin
                            duty_next[ch_reg] = duty_toward[ch_reg];
                        end else if (ch_reg == 2'd3) begin
                            state_next  = ST_RUN;
                            irq_next[0] = 1'b1;
                        end else begin
                            ch_next = ch_reg + 2'd1;
                        end
`else
                        // All channels together; leave once every one has arrived.
                        if (&at_target) begin
                            state_next  = ST_RUN;
                            irq_next[0] = 1'b1;
                        end else begin
                            duty_next = duty_toward;
                        end
`endif
                    end
                end

                ST_RUN: begin
                    if (stop_reg) begin
                        state_next = ST_STOP;
`ifdef PWM_SEQ_STAGGER_EN
                        ch_next    = '0;
`endif
                    end else if (tick) begin
                        duty_next = duty_toward;
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (&is_zero) begin
                            state_next = ST_IDLE;
                        end else begin
                            duty_next = duty_dec;
                        end
                    end
                end

                ST_FAULT: begin
                    for (int n = 0; n < 4; n++) begin
                        duty_next[n] = '0;
                    end
                    if (clr_reg && !fault_sync_reg) begin
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign irq_o = irq_reg;

endmodule

// File: tb/tb_pwm_soft_start_sequencer.sv
// Directed bench for pwm_soft_start_sequencer: register table, ack spacing,
// soft-start ramp, stop ramp-down, fault handling and asynchronous reset.
module tb_pwm_soft_start_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fault;
    logic [31:0] duty;
    logic [1:0]  irq;

    int passed = 0;
    int total  = 0;

    pwm_soft_start_sequencer_if wb_if ();

    pwm_soft_start_sequencer #(
        .DUTY_W (8),
        .DIV_W  (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .wbs      (wb_if),
        .fault_i  (fault),
        .duty_o   (duty),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = we;
        wb_if.wbs_adr_i = {28'd0, a, 2'b00};
        wb_if.wbs_dat_i = d;
        wb_if.wbs_sel_i = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_if.wbs_ack_o && n < 8);
        if (!wb_if.wbs_ack_o) begin
            total++;
            $display("FAIL wb_ack_timeout: got ack=0 expected ack=1");
        end
        rd = wb_if.wbs_dat_o;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        $display("wb %s adr=%0d dat=0x%08h sel=%b rd=0x%08h", we ? "wr" : "rd", a, d, s, rd);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [3:0]  ack_pat;
        logic        irq_seen;
        int          k_irq;
        logic [31:0] exp_k, exp_d2, exp_d5, exp_run_status;

`ifdef PWM_SEQ_STAGGER_EN
        exp_k          = 15;
        exp_d2         = 32'h0000_0001;
        exp_d5         = 32'h0000_0201;
        exp_run_status = 32'h0000_000E;
`else
        exp_k          = 6;
        exp_d2         = 32'h0101_0101;
        exp_d5         = 32'h0403_0201;
        exp_run_status = 32'h0000_0002;
`endif

        //            we    adr    dat            sel      chk   exp
        tbl[0]  = '{1'b0, 2'd1, 32'h0,          4'hF, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 32'h0,          4'hF, 1'b1, 32'h0};
        tbl[2]  = '{1'b0, 2'd3, 32'h0,          4'hF, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 2'd0, 32'h0,          4'hF, 1'b1, 32'h0};
        tbl[4]  = '{1'b1, 2'd2, 32'hFFFF_1234,  4'h3, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 2'd2, 32'h0,          4'hF, 1'b1, 32'h0000_1234};
        tbl[6]  = '{1'b1, 2'd2, 32'h0000_AB00,  4'h1, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 2'd2, 32'h0,          4'hF, 1'b1, 32'h0000_1200};
        tbl[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'd3, 32'h0,          4'hF, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 2'd1, 32'hFFFF_FFFF,  4'h4, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 2'd1, 32'h0,          4'hF, 1'b1, 32'h00FF_0000};
        tbl[12] = '{1'b1, 2'd1, 32'h0403_0201,  4'hF, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 2'd1, 32'h0,          4'hF, 1'b1, 32'h0403_0201};
        tbl[14] = '{1'b1, 2'd2, 32'h0,          4'hF, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 2'd2, 32'h0,          4'hF, 1'b1, 32'h0};

        rst_n = 1'b0;
        fault = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_adr_i = 32'h0;
        wb_if.wbs_dat_i = 32'h0;

        // Reset values
        wait_cycles(3);
        check("rst_duty", duty, 32'h0);
        check("rst_irq", {30'd0, irq}, 32'h0);
        check("rst_ack", {31'd0, wb_if.wbs_ack_o}, 32'h0);
        check("rst_dat", wb_if.wbs_dat_o, 32'h0);
        rst_n = 1'b1;

        // Register table
        for (int i = 0; i < 16; i++) begin
            wb_xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
            if (tbl[i].chk) check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end

        // Held strobe: ack every other cycle, never back-to-back
        @(negedge clk);
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = 32'h8;
        ack_pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack_pat = {ack_pat[2:0], wb_if.wbs_ack_o};
        end
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        check("ack_spacing", {28'd0, ack_pat}, 32'h0000_000A);

        // Soft-start ramp: TARGET=0x04030201, STEP_DIV=0
        wb_xfer(1'b1, 2'd0, 32'h1, 4'hF, rd);
        k_irq = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) check("ramp_duty_k2", duty, exp_d2);
            if (k == 5) check("ramp_duty_k5", duty, exp_d5);
            if (irq[0]) begin
                k_irq = k;
                break;
            end
        end
        check("ramp_irq_cycle", k_irq, exp_k);
        check("ramp_final_duty", duty, 32'h0403_0201);
        @(negedge clk);
        check("ramp_irq_width", {30'd0, irq}, 32'h0);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("run_status", rd, exp_run_status);

        // RUN follows a new target; START in RUN is ignored
        wb_xfer(1'b1, 2'd1, 32'h1010_1010, 4'hF, rd);
        wait_cycles(20);
        check("run_track_duty", duty, 32'h1010_1010);
        wb_xfer(1'b1, 2'd0, 32'h1, 4'hF, rd);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("start_in_run_ignored", rd, exp_run_status);

        // STOP: parallel ramp-down, status shows RAMP ch0, no irq
        wb_xfer(1'b1, 2'd0, 32'h2, 4'hF, rd);
        irq_seen = 1'b0;
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("stopping_status", rd, 32'h1);
        check("stop_duty_k2", duty, 32'h0F0F_0F0F);
        for (int k = 3; k <= 17; k++) begin
            @(negedge clk);
            if (irq != 2'b00) irq_seen = 1'b1;
        end
        check("stop_duty_zero", duty, 32'h0);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("stop_idle_status", rd, 32'h0);
        check("stop_no_irq", {31'd0, irq_seen}, 32'h0);

        // Prescaled ramp on channel 0 only, then a fault mid-ramp
        wb_xfer(1'b1, 2'd1, 32'h0, 4'hF, rd);
        wb_xfer(1'b1, 2'd2, 32'h3, 4'hF, rd);
        wb_xfer(1'b1, 2'd1, 32'hFFFF_FF10, 4'h1, rd);
        wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, rd);
        check("sel_byte0_target", rd, 32'h0000_0010);
        wb_xfer(1'b1, 2'd0, 32'h1, 4'hF, rd);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 4)  check("div_duty_k4", duty, 32'h0);
            if (k == 5)  check("div_duty_k5", duty, 32'h1);
            if (k == 9)  check("div_duty_k9", duty, 32'h2);
            if (k == 10) fault = 1'b1;
            if (k == 12) check("fault_not_yet", duty, 32'h2);
            if (k == 13) begin
                check("fault_duty_clear", duty, 32'h0);
                check("fault_irq", {30'd0, irq}, 32'h2);
            end
            if (k == 14) check("fault_irq_width", {30'd0, irq}, 32'h0);
        end
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("fault_status", rd, 32'h33);
        wb_xfer(1'b1, 2'd0, 32'h4, 4'hF, rd);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("clr_while_high_ignored", rd, 32'h33);
        fault = 1'b0;
        wait_cycles(4);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("fault_low_status", rd, 32'h13);
        wb_xfer(1'b1, 2'd0, 32'h4, 4'hF, rd);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("fault_clr_idle", rd, 32'h0);
        check("fault_clr_duty", duty, 32'h0);

        // Asynchronous reset mid-ramp
        wb_xfer(1'b1, 2'd0, 32'h1, 4'hF, rd);
        wait_cycles(10);
        check("pre_reset_duty", duty, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_duty", duty, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, rd);
        check("post_reset_target", rd, 32'h0);
        wb_xfer(1'b0, 2'd2, 32'h0, 4'hF, rd);
        check("post_reset_div", rd, 32'h0);
        wb_xfer(1'b0, 2'd3, 32'h0, 4'hF, rd);
        check("post_reset_status", rd, 32'h0);
        check("post_reset_duty", duty, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
